iscas_bist_harness: RTL and testbench

//  Self-test harness that sits opposite a sequential benchmark core such as s298:
//  it generates the core's input vectors and compacts the core's outputs.
//  - Stimulus: an LFSR drives dut_in.
//  - Response: a MISR compacts dut_out into a signature.
//  - Result: a pass flag, set when the signature equals golden_sig.
//  The harness lets an app be checked on-fabric with no host vectors.

---
 rtl/iscas_bist_harness.sv | 157 +++++++++++++++
 tb/tb_iscas_bist_harness.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/iscas_bist_harness.sv
// BIST harness for a sequential benchmark core: LFSR stimulus on dut_in, MISR
// compaction of dut_out, and a pass flag against a golden signature.
module iscas_bist_harness #(
  parameter int                  IN_W         = 3,
  parameter int                  OUT_W        = 6,
  parameter int                  LFSR_W       = 16,
  parameter logic [LFSR_W-1:0]   LFSR_TAPS    = 16'hB400,
  parameter logic [LFSR_W-1:0]   SEED         = 16'hACE1,
  parameter int                  MISR_W       = 16,
  parameter logic [MISR_W-1:0]   MISR_POLY    = 16'h1021,
  parameter int                  INIT_CYCLES  = 2,
  parameter logic [IN_W-1:0]     INIT_VEC     = 3'b000,
  parameter int                  NUM_PATTERNS = 1024,
  parameter int                  LATENCY      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MISR_W-1:0] golden_sig,
  input  logic [OUT_W-1:0]  dut_out,
  output logic [IN_W-1:0]   dut_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature
);

  localparam int CNT_M1  = (INIT_CYCLES > NUM_PATTERNS) ? INIT_CYCLES : NUM_PATTERNS;
  localparam int CNT_MAX = (CNT_M1 > LATENCY) ? CNT_M1 : LATENCY;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  INIT_LD  = CNT_W'((INIT_CYCLES > 0) ? INIT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0]  RUN_LD   = CNT_W'(NUM_PATTERNS - 1);
  localparam logic [CNT_W-1:0]  DRAIN_LD = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [MISR_W-1:0]   misr_q, misr_d, misr_next;
  logic                pass_q, pass_d;
  logic [IN_W-1:0]     dut_in_q, dut_in_d;
  logic                accept;
  logic                compact;

  // start is a single-cycle request with no ready; it is only honoured in IDLE/DONE.
  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lfsr_q   <= SEED_EFF;
      misr_q   <= '0;
      pass_q   <= 1'b0;
      dut_in_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      misr_q   <= misr_d;
      pass_q   <= pass_d;
      dut_in_q <= dut_in_d;
    end
  end

  // Single down-counter, reloaded with the residency of whichever state is entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (INIT_CYCLES > 0) begin
            state_d = S_INIT;
            cnt_d   = INIT_LD;
          end else begin
            state_d = S_RUN;
            cnt_d   = RUN_LD;
          end
        end
      end
      S_INIT: begin
        if (cnt_q == '0) begin
          state_d = S_RUN;
          cnt_d   = RUN_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          if (LATENCY > 0) begin
            state_d = S_DRAIN;
            cnt_d   = DRAIN_LD;
          end else begin
            state_d = S_DONE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // RUN cycle index k = NUM_PATTERNS-1-cnt; the first LATENCY responses are stale.
  always_comb begin
    compact   = ((state_q == S_RUN) && ((NUM_PATTERNS - 1 - int'(cnt_q)) >= LATENCY))
                || (state_q == S_DRAIN);
    misr_next = {misr_q[MISR_W-2:0], 1'b0} ^ (misr_q[MISR_W-1] ? MISR_POLY : '0)
                ^ MISR_W'(dut_out);

    lfsr_d = lfsr_q;
    misr_d = misr_q;
    pass_d = pass_q;
    if (accept) begin
      lfsr_d = SEED_EFF;
      misr_d = '0;
      pass_d = 1'b0;
    end else begin
      if (state_q == S_RUN) lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
      if (compact)          misr_d = misr_next;
      if ((state_d == S_DONE) && (state_q != S_DONE)) pass_d = (misr_d == golden_sig);
    end

    // dut_in is registered from next-state values so it lines up with the RUN cycle.
    unique case (state_d)
      S_INIT:  dut_in_d = INIT_VEC;
      S_RUN:   dut_in_d = lfsr_d[IN_W-1:0];
      default: dut_in_d = '0;
    endcase
  end

  always_comb begin
    busy      = (state_q == S_INIT) || (state_q == S_RUN) || (state_q == S_DRAIN);
    done      = (state_q == S_DONE);
    pass      = pass_q;
    signature = misr_q;
    dut_in    = dut_in_q;
  end

endmodule

// File: tb/tb_iscas_bist_harness.sv
// Bench for iscas_bist_harness: small run length, tied and registered-core
// responses, expected stimulus and signature rebuilt from the LFSR/MISR rules.
module tb_iscas_bist_harness;

  localparam int          IN_W  = 3;
  localparam int          OUT_W = 6;
  localparam int          NP    = 4;
  localparam int          IC    = 2;
  localparam int          LAT   = 1;
  localparam int          RUN_LEN = IC + NP + LAT;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam logic [15:0] TAPS  = 16'hB400;
  localparam logic [15:0] POLY  = 16'h1021;
  localparam logic [2:0]  IVEC  = 3'b000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [15:0]      golden_sig = '0;
  logic [OUT_W-1:0] dut_out;
  logic [IN_W-1:0]  dut_in;
  logic             busy, done, pass;
  logic [15:0]      signature;

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0] core_q  = '0;
  logic [5:0] core_k  = '0;
  logic [5:0] tie_val = '0;
  logic       tie_en  = 1'b1;
  logic [5:0] out_q[$];
  logic [2:0] in_q[$];
  logic [15:0] s_a, s_b, s_clean;

  iscas_bist_harness #(
    .IN_W(IN_W), .OUT_W(OUT_W), .INIT_CYCLES(IC), .INIT_VEC(IVEC),
    .NUM_PATTERNS(NP), .LATENCY(LAT)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .golden_sig(golden_sig),
    .dut_out(dut_out), .dut_in(dut_in), .busy(busy), .done(done),
    .pass(pass), .signature(signature)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Stand-in registered core: two cycles of a constant input flush its state.
  always @(posedge clk) core_q <= {core_q[2:0], dut_in} ^ core_k;
  assign dut_out = tie_en ? tie_val : core_q;

  always @(negedge clk) begin
    if (busy) begin
      out_q.push_back(dut_out);
      in_q.push_back(dut_in);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & TAPS)};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [5:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? POLY : 16'h0000) ^ {10'h000, d};
  endfunction

  // One full run; poke > 0 pulses start that many edges after acceptance.
  task automatic run_once(input logic [15:0] golden, input int poke, output logic [15:0] exp_sig);
    int          n;
    logic [15:0] lf;
    logic [2:0]  exp_in;
    out_q.delete();
    in_q.delete();
    @(negedge clk);
    golden_sig = golden;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("busy_rise", busy, 1);
    check_eq("done_drop", done, 0);
    check_eq("sig_clear", signature, 0);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
      start = (n == poke);
    end
    start = 1'b0;
    check_eq("done_latency", n, RUN_LEN);
    check_eq("busy_fall", busy, 0);
    check_eq("stim_len", in_q.size(), RUN_LEN);
    lf      = SEED;
    exp_sig = '0;
    for (int i = 0; i < in_q.size() && i < RUN_LEN; i++) begin
      if (i < IC) exp_in = IVEC;
      else if (i < IC + NP) begin
        exp_in = lf[2:0];
        lf     = lfsr_step(lf);
      end else exp_in = 3'b000;
      check_eq("dut_in", in_q[i], exp_in);
      if (i >= IC + LAT) exp_sig = misr_step(exp_sig, out_q[i]);
    end
    check_eq("signature", signature, exp_sig);
    check_eq("pass", pass, golden == exp_sig);
    check_eq("sig_no_x", $isunknown(signature), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_dut_in", dut_in, 0);
    check_eq("rst_sig", signature, 0);

    // Tied response 1: four compactions of 1 give 0x000F.
    tie_en  = 1'b1;
    tie_val = 6'h01;
    run_once(16'h000F, -1, s_a);
    check_eq("first_run_vec0", in_q[2], 3'b001);
    check_eq("first_run_vec1", in_q[3], 3'b011);
    check_eq("sig_const", signature, 16'h000F);
    check_eq("pass_const", pass, 1);
    run_once(16'h000E, -1, s_a);
    check_eq("fail_const", pass, 0);

    // Tied zero, then restart from DONE.
    tie_val = 6'h00;
    run_once(16'h0000, -1, s_a);
    check_eq("zero_pass", pass, 1);
    run_once(16'h0000, -1, s_b);
    check_eq("zero_rerun", signature, s_a);

    // Registered core, start pokes mid-run and an async reset mid-run.
    tie_en = 1'b0;
    core_k = 6'h2B;
    run_once(16'h1234, -1, s_clean);
    run_once(s_clean, 3, s_b);
    check_eq("poke_same_sig", signature, s_clean);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_pass", pass, 0);
    check_eq("arst_dut_in", dut_in, 0);
    check_eq("arst_sig", signature, 0);
    @(negedge clk) rst = 1'b0;
    run_once(s_clean, -1, s_b);
    check_eq("post_rst_sig", signature, s_clean);

    // Randomized cores and goldens; each second run reuses the first signature.
    for (int r = 0; r < 8; r++) begin
      core_k = 6'($urandom_range(0, 63));
      run_once(16'($urandom), -1, s_a);
      run_once(s_a, int'($urandom_range(0, 6)), s_b);
      check_eq("rand_repeat", signature, s_a);
      check_eq("rand_pass", pass, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
